// File: rtl/enc32_5_scanner.sv
// enc32_5_scanner: sequential set-bit encoder. Accepts a WIDTH-bit vector and
// emits the index of every set bit, lowest first, one index per output beat.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready/in_vec    input handshake and vector
//   out_valid/out_ready         output handshake
//   out_idx, out_last           current set-bit index, highest-set-bit marker
//   vec_count                   popcount of the most recently accepted vector
//   zero_flag                   one-cycle pulse when an all-zero vector is accepted
//   busy                        scanning a vector

module enc32_5_scanner #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   vec_count,
  output logic             zero_flag,
  output logic             busy
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_q, zero_d;

  logic               accept;
  logic               beat;
  logic [IDX_W-1:0]   in_lsb;
  logic [IDX_W-1:0]   pend_lsb;
  logic [WIDTH-1:0]   in_rest;
  logic [WIDTH-1:0]   pend_rest;
  logic [CNT_W-1:0]   in_cnt;

  // Priority encoder from bit 0 upward; returns 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lsb_index(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Population count of the incoming vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Handshake decode; in_ready opens during the final beat so the next
  // vector loads with no bubble.
  assign beat     = (state_q == SCAN) & out_ready;
  assign in_ready = (state_q == IDLE) | (beat & last_q);
  assign accept   = in_valid & in_ready;

  // v & (v - 1) clears the lowest set bit.
  assign in_lsb    = lsb_index(in_vec);
  assign in_rest   = in_vec & (in_vec - WIDTH'(1));
  assign pend_lsb  = lsb_index(pending_q);
  assign pend_rest = pending_q & (pending_q - WIDTH'(1));
  assign in_cnt    = popcount(in_vec);

  // Next-state: accept has priority over the return to IDLE on a final beat.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    zero_d    = 1'b0;

    if (accept) begin
      cnt_d = in_cnt;
      if (in_vec != '0) begin
        state_d   = SCAN;
        idx_d     = in_lsb;
        pending_d = in_rest;
        last_d    = (in_rest == '0);
      end else begin
        state_d = IDLE;
        zero_d  = 1'b1;
      end
    end else if (beat) begin
      if (!last_q) begin
        idx_d     = pend_lsb;
        pending_d = pend_rest;
        last_d    = (pend_rest == '0);
      end else begin
        state_d = IDLE;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
    end
  end

  // out_valid coincides with SCAN: every path into SCAN loads an index.
  assign out_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign vec_count = cnt_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_enc32_5_scanner.sv
// Testbench for enc32_5_scanner: table of per-cycle vectors plus hand-written
// sequences for the all-ones scan and asynchronous reset.

module tb_enc32_5_scanner;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [5:0]  vec_count;
  logic        zero_flag;
  logic        busy;

  int errors = 0;
  int checks = 0;

  enc32_5_scanner dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .vec_count (vec_count),
    .zero_flag (zero_flag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs driven for a cycle and outputs expected in that cycle
  // (before the next rising edge). idx/last are only checked when valid.
  typedef struct {
    logic        iv;
    logic [31:0] vec;
    logic        ordy;
    logic        ev;
    logic [4:0]  eidx;
    logic        elast;
    logic [5:0]  ecnt;
    logic        ezero;
    logic        erdy;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(logic iv, logic [31:0] vec, logic ordy, logic ev,
                              logic [4:0] eidx, logic elast, logic [5:0] ecnt,
                              logic ezero, logic erdy);
    row_t r;
    r.iv = iv; r.vec = vec; r.ordy = ordy; r.ev = ev; r.eidx = eidx;
    r.elast = elast; r.ecnt = ecnt; r.ezero = ezero; r.erdy = erdy;
    return r;
  endfunction

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, tag, act, exp);
    end
  endtask

  task automatic check_row(input row_t r, input int tag);
    chk("out_valid", tag, 32'(out_valid), 32'(r.ev));
    chk("busy", tag, 32'(busy), 32'(r.ev));
    chk("vec_count", tag, 32'(vec_count), 32'(r.ecnt));
    chk("zero_flag", tag, 32'(zero_flag), 32'(r.ezero));
    chk("in_ready", tag, 32'(in_ready), 32'(r.erdy));
    if (r.ev) begin
      chk("out_idx", tag, 32'(out_idx), 32'(r.eidx));
      chk("out_last", tag, 32'(out_last), 32'(r.elast));
    end
  endtask

  task automatic run_row(input row_t r, input int tag);
    @(negedge clk);
    in_valid  = r.iv;
    in_vec    = r.vec;
    out_ready = r.ordy;
    #1;
    check_row(r, tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b0;

    // Reset state while reset is held.
    #3;
    check_row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1000);
    chk("rst_out_idx", 1000, 32'(out_idx), 32'd0);
    chk("rst_out_last", 1000, 32'(out_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    //            iv vec           ordy ev idx last cnt zero rdy
    // Basic scan 0x8000_0011
    rows.push_back(mk(1, 32'h8000_0011, 1, 0,  0, 0, 0, 0, 1));
    rows.push_back(mk(0, 32'hDEAD_BEEF, 1, 1,  0, 0, 3, 0, 0));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1,  4, 0, 3, 0, 0));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1, 31, 1, 3, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 3, 0, 1));
    // Backpressure 0x6
    rows.push_back(mk(1, 32'h0000_0006, 0, 0,  0, 0, 3, 0, 1));
    rows.push_back(mk(0, 32'hFFFF_0000, 0, 1,  1, 0, 2, 0, 0));
    rows.push_back(mk(1, 32'h0000_0001, 0, 1,  1, 0, 2, 0, 0));
    rows.push_back(mk(0, 32'h0000_0000, 0, 1,  1, 0, 2, 0, 0));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1,  1, 0, 2, 0, 0));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1,  2, 1, 2, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 2, 0, 1));
    // Zero vector
    rows.push_back(mk(1, 32'h0000_0000, 1, 0,  0, 0, 2, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 0, 1, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 0, 0, 1));
    // Back-to-back 0x300 then 0x1
    rows.push_back(mk(1, 32'h0000_0300, 1, 0,  0, 0, 0, 0, 1));
    rows.push_back(mk(1, 32'h0000_0001, 1, 1,  8, 0, 2, 0, 0));
    rows.push_back(mk(1, 32'h0000_0001, 1, 1,  9, 1, 2, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1,  0, 1, 1, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 1, 0, 1));
    // Zero vector accepted on a final beat
    rows.push_back(mk(1, 32'h0000_0004, 1, 0,  0, 0, 1, 0, 1));
    rows.push_back(mk(1, 32'h0000_0000, 1, 1,  2, 1, 1, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 0, 1, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 0, 0, 1));
    // Bit 31 alone
    rows.push_back(mk(1, 32'h8000_0000, 1, 0,  0, 0, 0, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 1, 31, 1, 1, 0, 1));
    rows.push_back(mk(0, 32'h0000_0000, 1, 0,  0, 0, 1, 0, 1));

    for (int i = 0; i < rows.size(); i++) begin
      run_row(rows[i], i);
    end

    // All ones: indices 0..31, last only on 31.
    run_row(mk(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 1, 0, 1), 200);
    for (int i = 0; i < 32; i++) begin
      run_row(mk(0, 32'h0, 1, 1, 5'(i), (i == 31), 32, 0, (i == 31)), 201 + i);
    end
    run_row(mk(0, 32'h0, 1, 0, 0, 0, 32, 0, 1), 233);

    // Reset mid-scan: five beats (0..4), then async reset between edges.
    run_row(mk(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 32, 0, 1), 300);
    for (int i = 0; i < 5; i++) begin
      run_row(mk(0, 32'h0, 1, 1, 5'(i), 0, 32, 0, 0), 301 + i);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_row(mk(0, 32'h0, 1, 0, 0, 0, 0, 0, 1), 306);
    chk("rst_out_idx", 306, 32'(out_idx), 32'd0);
    chk("rst_out_last", 306, 32'(out_last), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_row(mk(0, 32'h0, 1, 0, 0, 0, 0, 0, 1), 307);
    run_row(mk(0, 32'h0, 1, 0, 0, 0, 0, 0, 1), 308);
    run_row(mk(1, 32'h0000_0010, 1, 0, 0, 0, 0, 0, 1), 309);
    run_row(mk(0, 32'h0, 1, 1, 4, 1, 1, 0, 1), 310);
    run_row(mk(0, 32'h0, 1, 0, 0, 0, 1, 0, 1), 311);
    run_row(mk(0, 32'h0, 1, 0, 0, 0, 1, 0, 1), 312);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enc32_5_scanner.md
Name: enc32_5_scanner

Overview:
- Sequential set-bit encoder, the inverse of the 5:32 register-select decode: accepts a 32-bit vector and emits the 5-bit index of every set bit, lowest index first, one index per beat.
- Used for multi-bit select and mask vectors, such as register-writeback masks and hazard/forwarding match vectors, that must be serialised into register numbers.
- Valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 32, input vector width; power of two, 2..32.
- IDX_W, 5, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_vec is presented.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  WIDTH  vector to encode.
- out_valid  output  1  out_idx holds a valid index.
- out_ready  input  1  consumer takes out_idx this cycle.
- out_idx  output  IDX_W  index of the current set bit.
- out_last  output  1  current index is the highest set bit of the vector.
- vec_count  output  IDX_W+1  popcount of the most recently accepted vector.
- zero_flag  output  1  one-cycle pulse: an all-zero vector was accepted.
- busy  output  1  state is SCAN.

Behaviour:
- Reset (reset_n low, asynchronous, effective immediately):
  - state=IDLE, pending=0.
  - out_valid=0, out_idx=0, out_last=0, vec_count=0, zero_flag=0, busy=0.
  - in_ready=1 once state is IDLE.
- Reset mid-operation discards the pending vector. No further indices are emitted.
- States are IDLE and SCAN. busy = (state==SCAN).
- in_ready = (state==IDLE) | (out_valid & out_last & out_ready).
  - in_ready is combinational on out_ready. This allows back-to-back vectors with no bubble.
- Accept = in_valid & in_ready. On accept with in_vec != 0:
  - out_idx <= lowest set bit index of in_vec.
  - pending <= in_vec with that bit cleared.
  - out_last <= (that cleared vector == 0).
  - out_valid <= 1; vec_count <= popcount(in_vec); state <= SCAN.
  - Latency: first index is valid the cycle after accept.
- On accept with in_vec == 0:
  - No index is emitted; zero_flag <= 1 for exactly one cycle; vec_count <= 0.
  - state <= IDLE, or drops to IDLE when the accept coincides with a final beat.
- zero_flag is 0 in every other cycle.
- Output beat = out_valid & out_ready. On a beat with out_last=0:
  - out_idx <= lowest set bit of pending; that bit is cleared.
  - out_last <= (updated pending == 0).
- On a beat with out_last=1 and no simultaneous accept: out_valid <= 0, state <= IDLE.
- Final beat with a simultaneous accept: the new vector loads exactly as from IDLE. The accept path takes priority over the return to IDLE.
- Backpressure: while out_valid & !out_ready, out_idx, out_last and pending are held stable and in_ready=0.
- Throughput: one index per cycle while out_ready=1. A vector with N set bits occupies exactly N beats.
- in_vec is sampled only on accept. Changes to in_vec at other times are ignored.
- vec_count holds its value until the next accept.
- Boundary vectors:
  - Single bit: out_last=1 on the first beat.
  - All ones: indices 0..31, out_last only on index 31, vec_count=32.
  - Bit 31 alone: out_idx=31, with no wrap in the index arithmetic.
- The lowest-set-bit search is a combinational priority encoder from bit 0 upward. Only index 0 with pending==0 is undefined, and that case is never loaded.

Test Plan:
- Reset: hold reset_n=0, then release. Required: all outputs 0 and in_ready=1. Assert reset_n low asynchronously between edges; outputs must clear without a clock.
- Basic scan: in_vec=32'h8000_0011 with out_ready=1. Required: out_idx 0, 4, 31 on three consecutive cycles starting the cycle after accept; out_last only with 31; vec_count=3; then out_valid=0 and in_ready=1.
- Backpressure: in_vec=32'h0000_0006, out_ready=0 for 3 cycles, then 1. Required: out_idx=1 held for 3 cycles with in_ready=0, then beats 1 and 2 with out_last on 2.
- Zero vector: accept in_vec=0. Required: zero_flag high exactly one cycle, out_valid stays 0, vec_count=0, in_ready stays 1.
- Back-to-back: vector 32'h0000_0300, then in_vec=32'h0000_0001 with in_valid held high. Required: second vector accepted in the same cycle as the idx=9 beat, out_idx=0 the very next cycle with no bubble, vec_count=1.
- Reset mid-scan: in_vec=32'hFFFF_FFFF, assert reset_n low after 5 beats (indices 0..4 emitted). Required: out_valid=0 immediately. After release, IDLE with no residual indices; a new vector 32'h0000_0010 yields only idx=4.
